// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send,
// then shifts one byte + odd parity out on device clock falling edges.
// Ports:
//   CLOCK_50, resetn        - system clock, async active-low reset
//   tx_start, tx_data       - one-cycle send request and byte
//   PS2_CLK, PS2_DAT        - raw (async) bus pin levels
//   ps2_clk_oe, ps2_dat_oe  - 1 = pull the line low
//   tx_busy, tx_done        - transfer in progress / ACKed pulse
//   tx_error, tx_err_code   - abort pulse, 01 start, 10 packet, 11 no ACK
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int START_TIMEOUT  = 750000,
    parameter int PACKET_TIMEOUT = 100000,
    parameter int TMR_W          = 20
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic [1:0] tx_err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_XFER,
        S_ACK,
        S_WAITIDLE
    } state_t;

    localparam logic [TMR_W-1:0] INH_LAST  = TMR_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMR_W-1:0] INH_SETUP = TMR_W'(INHIBIT_CYCLES - 2);
    localparam logic [TMR_W-1:0] ST_LAST   = TMR_W'(START_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] PT_LAST   = TMR_W'(PACKET_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

    state_t           r_state;
    logic [TMR_W-1:0] r_tmr;
    logic [7:0]       r_data;
    logic             r_par;
    logic [3:0]       r_n;
    logic [2:0]       r_clk_sync;
    logic [1:0]       r_dat_sync;

    logic             w_fe;
    logic             w_clk;
    logic             w_dat;
    logic [TMR_W-1:0] w_tmr_inc;
    logic [1:0]       w_err;

    // Idle bus is high, so the synchronisers reset to 1 to avoid a
    // spurious falling edge straight out of reset.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_clk_sync <= 3'b111;
            r_dat_sync <= 2'b11;
        end else begin
            r_clk_sync <= {r_clk_sync[1:0], PS2_CLK};
            r_dat_sync <= {r_dat_sync[0], PS2_DAT};
        end
    end

    assign w_clk = r_clk_sync[1];
    assign w_dat = r_dat_sync[1];
    assign w_fe  = r_clk_sync[2] & ~r_clk_sync[1];

    // Saturating increment: a stuck bus must not wrap the timer
    // back below a timeout threshold.
    assign w_tmr_inc = (&r_tmr) ? r_tmr : r_tmr + TMR_ONE;

    // Abort decode; a device edge in REQ wins over a coincident timeout.
    always_comb begin
        w_err = 2'b00;
        unique case (r_state)
            S_REQ: begin
                if (!w_fe && r_tmr == ST_LAST) w_err = 2'b01;
            end
            S_XFER, S_WAITIDLE: begin
                if (r_tmr == PT_LAST) w_err = 2'b10;
            end
            S_ACK: begin
                if (r_tmr == PT_LAST)   w_err = 2'b10;
                else if (w_fe && w_dat) w_err = 2'b11;
            end
            default: w_err = 2'b00;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_tmr       <= '0;
            r_data      <= '0;
            r_par       <= 1'b0;
            r_n         <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_dat_oe  <= 1'b0;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
            tx_err_code <= 2'b00;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            r_tmr    <= w_tmr_inc;
            if (w_err != 2'b00) begin
                ps2_clk_oe  <= 1'b0;
                ps2_dat_oe  <= 1'b0;
                tx_error    <= 1'b1;
                tx_err_code <= w_err;
                r_state     <= S_IDLE;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        tx_busy    <= 1'b0;
                        // tx_busy is still 1 in the cycle after a
                        // done/error pulse, so a start there is dropped.
                        if (tx_start && !tx_busy) begin
                            r_data      <= tx_data;
                            r_par       <= ~^tx_data;
                            tx_err_code <= 2'b00;
                            tx_busy     <= 1'b1;
                            ps2_clk_oe  <= 1'b1;
                            r_tmr       <= '0;
                            r_state     <= S_INHIBIT;
                        end
                    end
                    S_INHIBIT: begin
                        if (r_tmr == INH_LAST) begin
                            ps2_clk_oe <= 1'b0;
                            r_tmr      <= '0;
                            r_state    <= S_REQ;
                        end else if (r_tmr == INH_SETUP) begin
                            ps2_dat_oe <= 1'b1;
                        end
                    end
                    S_REQ: begin
                        if (w_fe) begin
                            ps2_dat_oe <= ~r_data[0];
                            r_n        <= 4'd1;
                            r_tmr      <= '0;
                            r_state    <= S_XFER;
                        end
                    end
                    S_XFER: begin
                        if (w_fe) begin
                            r_n <= r_n + 4'd1;
                            if (r_n == 4'd9) begin
                                ps2_dat_oe <= 1'b0;
                                r_state    <= S_ACK;
                            end else if (r_n == 4'd8) begin
                                ps2_dat_oe <= ~r_par;
                            end else begin
                                ps2_dat_oe <= ~r_data[r_n[2:0]];
                            end
                        end
                    end
                    S_ACK: begin
                        if (w_fe) r_state <= S_WAITIDLE;
                    end
                    S_WAITIDLE: begin
                        if (w_clk && w_dat) begin
                            tx_done <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: an open-drain bus with a
// behavioural keyboard that clocks frames and compares against 11-bit frames.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INH = 40;
    localparam int ST  = 600;
    localparam int PT  = 1500;
    localparam int TW  = 12;
    localparam int H   = 16;

    logic       CLOCK_50 = 1'b0;
    logic       resetn;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       PS2_CLK;
    logic       PS2_DAT;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;
    logic [1:0] tx_err_code;

    logic dev_clk_low;
    logic dev_dat_low;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int err_cyc  = 0;
    int req_cyc  = 0;
    int oe_rise  = 0;
    int fall_cyc = 0;
    logic [1:0] err_code_seen = 2'b00;
    logic [1:0] err_oe = 2'b00;
    logic prev_oe = 1'b0;

    // Wired-AND bus: either side pulling low wins.
    assign PS2_CLK = ~(ps2_clk_oe | dev_clk_low);
    assign PS2_DAT = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .START_TIMEOUT (ST),
        .PACKET_TIMEOUT(PT),
        .TMR_W         (TW)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .PS2_CLK    (PS2_CLK),
        .PS2_DAT    (PS2_DAT),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .tx_err_code(tx_err_code)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    always @(negedge CLOCK_50) begin
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_error) begin
            err_cnt       <= err_cnt + 1;
            err_cyc       <= cyc;
            err_code_seen <= tx_err_code;
            err_oe        <= {ps2_clk_oe, ps2_dat_oe};
        end
        if (prev_oe && !ps2_clk_oe) req_cyc <= cyc;
        if (!prev_oe && ps2_clk_oe) oe_rise <= oe_rise + 1;
        prev_oe <= ps2_clk_oe;
    end

    // Reference frame: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] frame(input logic [7:0] d);
        logic par;
        par = ($countones(d) % 2 == 0);
        return {1'b1, par, d, 1'b0};
    endfunction

    task automatic start_tx(input logic [7:0] d);
        @(negedge CLOCK_50);
        tx_start = 1'b1;
        tx_data  = d;
        @(negedge CLOCK_50);
        tx_start = 1'b0;
    endtask

    task automatic wait_idle(input int lim, output bit ok);
        int t;
        t = 0;
        @(negedge CLOCK_50);
        while (tx_busy && t < lim) begin
            @(negedge CLOCK_50);
            t++;
        end
        ok = !tx_busy;
        repeat (2) @(negedge CLOCK_50);
    endtask

    // Keyboard: wait for request-to-send, then clock nedges pulses,
    // sampling the data line before each rising edge.
    task automatic device_run(input int nedges, input bit ack,
                              output logic [10:0] got, output bit ok);
        int t;
        ok  = 1'b1;
        got = '0;
        t   = 0;
        while (!(PS2_CLK === 1'b1 && PS2_DAT === 1'b0 && tx_busy)
               && t < 2000) begin
            @(negedge CLOCK_50);
            t++;
        end
        if (t >= 2000) begin
            ok = 1'b0;
        end else begin
            got[0] = PS2_DAT;
            for (int k = 1; k <= nedges; k++) begin
                repeat (H) @(negedge CLOCK_50);
                if (k == 11 && ack) dev_dat_low = 1'b1;
                dev_clk_low = 1'b1;
                if (k == 1) fall_cyc = cyc;
                repeat (H) @(negedge CLOCK_50);
                if (k <= 10) got[k] = PS2_DAT;
                dev_clk_low = 1'b0;
            end
            repeat (H) @(negedge CLOCK_50);
            dev_dat_low = 1'b0;
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        checks++;
        if ({ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_error,
             tx_err_code} !== 7'b0) begin
            failures++;
            $display("FAIL reset_hold got=%b exp=0", {ps2_clk_oe,
                     ps2_dat_oe, tx_busy, tx_done, tx_error, tx_err_code});
        end
        resetn = 1'b1;
        repeat (5) @(negedge CLOCK_50);
        checks++;
        if ({ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_error,
             tx_err_code} !== 7'b0) begin
            failures++;
            $display("FAIL reset_idle got=%b exp=0", {ps2_clk_oe,
                     ps2_dat_oe, tx_busy, tx_done, tx_error, tx_err_code});
        end
    endtask

    task automatic test_known(input logic [7:0] d, input string nm);
        logic [10:0] got;
        bit ok, ok2;
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(d);
        device_run(11, 1'b1, got, ok);
        wait_idle(PT, ok2);
        checks++;
        if ((ok & ok2) !== 1'b1) begin
            failures++;
            $display("FAIL %s_handshake got=%b exp=1", nm, ok & ok2);
        end
        checks++;
        if (got !== frame(d)) begin
            failures++;
            $display("FAIL %s_bits got=%b exp=%b", nm, got, frame(d));
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL %s_done got=%0d exp=1", nm, done_cnt - d0);
        end
        checks++;
        if (err_cnt - e0 != 0) begin
            failures++;
            $display("FAIL %s_noerr got=%0d exp=0", nm, err_cnt - e0);
        end
        checks++;
        if (tx_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy got=%b exp=0", nm, tx_busy);
        end
    endtask

    task automatic test_inhibit;
        logic [10:0] got;
        bit ok, ok2;
        int cnt, dcnt, d0;
        logic last;
        cnt  = 0;
        dcnt = 0;
        last = 1'b0;
        d0   = done_cnt;
        start_tx(8'hF4);
        while (ps2_clk_oe && cnt < INH + 50) begin
            cnt++;
            if (ps2_dat_oe) dcnt++;
            last = ps2_dat_oe;
            @(negedge CLOCK_50);
        end
        checks++;
        if (cnt != INH) begin
            failures++;
            $display("FAIL inhibit_len got=%0d exp=%0d", cnt, INH);
        end
        checks++;
        if (dcnt != 1 || last !== 1'b1) begin
            failures++;
            $display("FAIL inhibit_dat got=%0d/%b exp=1/1", dcnt, last);
        end
        device_run(11, 1'b1, got, ok);
        wait_idle(PT, ok2);
        checks++;
        if (got !== frame(8'hF4) || !ok || !ok2) begin
            failures++;
            $display("FAIL inhibit_bits got=%b exp=%b", got, frame(8'hF4));
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL inhibit_done got=%0d exp=1", done_cnt - d0);
        end
    endtask

    task automatic test_random;
        logic [7:0] d;
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom_range(0, 255));
            test_known(d, "random");
        end
    endtask

    task automatic test_start_timeout;
        bit ok;
        int e0, d0;
        e0 = err_cnt;
        d0 = done_cnt;
        start_tx(8'hAA);
        wait_idle(INH + ST + 100, ok);
        checks++;
        if (!ok || err_cnt - e0 != 1 || err_code_seen !== 2'b01) begin
            failures++;
            $display("FAIL start_to_code got=%0d/%b exp=1/01",
                     err_cnt - e0, err_code_seen);
        end
        checks++;
        if (err_cyc - req_cyc != ST) begin
            failures++;
            $display("FAIL start_to_time got=%0d exp=%0d",
                     err_cyc - req_cyc, ST);
        end
        checks++;
        if (err_oe !== 2'b00 || done_cnt != d0) begin
            failures++;
            $display("FAIL start_to_lines got=%b exp=00", err_oe);
        end
        checks++;
        if (tx_err_code !== 2'b01) begin
            failures++;
            $display("FAIL start_to_hold got=%b exp=01", tx_err_code);
        end
    endtask

    task automatic test_no_ack;
        logic [10:0] got;
        bit ok, ok2;
        int e0, d0;
        e0 = err_cnt;
        d0 = done_cnt;
        start_tx(8'h3C);
        device_run(11, 1'b0, got, ok);
        wait_idle(PT, ok2);
        checks++;
        if (!ok || !ok2 || err_cnt - e0 != 1 || tx_err_code !== 2'b11) begin
            failures++;
            $display("FAIL noack_code got=%0d/%b exp=1/11",
                     err_cnt - e0, tx_err_code);
        end
        checks++;
        if (done_cnt != d0) begin
            failures++;
            $display("FAIL noack_done got=%0d exp=0", done_cnt - d0);
        end
        checks++;
        if (got !== frame(8'h3C)) begin
            failures++;
            $display("FAIL noack_bits got=%b exp=%b", got, frame(8'h3C));
        end
    endtask

    task automatic test_packet_timeout;
        logic [10:0] got;
        logic [7:0] d;
        bit ok, ok2;
        int e0, d0, r0;
        d  = 8'($urandom_range(0, 255));
        e0 = err_cnt;
        d0 = done_cnt;
        r0 = oe_rise;
        start_tx(d);
        repeat (10) @(negedge CLOCK_50);
        // A second request while busy must be ignored entirely.
        tx_start = 1'b1;
        tx_data  = ~d;
        @(negedge CLOCK_50);
        tx_start = 1'b0;
        device_run(5, 1'b0, got, ok);
        wait_idle(PT + 200, ok2);
        checks++;
        if (!ok || !ok2 || err_cnt - e0 != 1 || err_code_seen !== 2'b10) begin
            failures++;
            $display("FAIL pkt_to_code got=%0d/%b exp=1/10",
                     err_cnt - e0, err_code_seen);
        end
        // fe is acted on 3 cycles after the pin falls (synchroniser).
        checks++;
        if (err_cyc - fall_cyc != PT + 3) begin
            failures++;
            $display("FAIL pkt_to_time got=%0d exp=%0d",
                     err_cyc - fall_cyc, PT + 3);
        end
        checks++;
        if (got[4:0] !== {d[3:0], 1'b0}) begin
            failures++;
            $display("FAIL pkt_to_recapture got=%b exp=%b",
                     got[4:0], {d[3:0], 1'b0});
        end
        repeat (100) @(negedge CLOCK_50);
        checks++;
        if (oe_rise - r0 != 1 || tx_busy !== 1'b0 || done_cnt != d0
            || err_oe !== 2'b00) begin
            failures++;
            $display("FAIL pkt_to_extra got=%0d/%b exp=1/0",
                     oe_rise - r0, tx_busy);
        end
    endtask

    task automatic test_reset_mid;
        logic [10:0] got;
        bit ok;
        int e0, d0;
        e0 = err_cnt;
        d0 = done_cnt;
        start_tx(8'h96);
        device_run(4, 1'b0, got, ok);
        #3 resetn = 1'b0;
        #1;
        checks++;
        if ({ps2_clk_oe, ps2_dat_oe, tx_busy} !== 3'b000 || !ok) begin
            failures++;
            $display("FAIL rst_mid_async got=%b exp=000",
                     {ps2_clk_oe, ps2_dat_oe, tx_busy});
        end
        @(negedge CLOCK_50);
        resetn = 1'b1;
        repeat (5) @(negedge CLOCK_50);
        checks++;
        if (err_cnt != e0 || done_cnt != d0) begin
            failures++;
            $display("FAIL rst_mid_pulse got=%0d/%0d exp=0/0",
                     err_cnt - e0, done_cnt - d0);
        end
        test_known(8'h01, "after_rst");
    endtask

    initial begin
        resetn      = 1'b0;
        tx_start    = 1'b0;
        tx_data     = 8'h00;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        test_reset();
        test_known(8'hED, "ed");
        test_inhibit();
        test_random();
        test_start_timeout();
        test_no_ack();
        test_packet_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
